// File: rtl/intr_rr_arbiter.sv
// APB-programmable interrupt front-end: per-source pending/mask/priority, priority
// arbitration with round-robin tie-break, and a valid/ack/done handshake to one processor.
module intr_rr_arbiter #(
  parameter int unsigned NUM_SRC = 16,
  parameter int unsigned IDW     = $clog2(NUM_SRC),
  parameter int unsigned PRI_W   = 4
) (
  input  logic               pclk_i,
  input  logic               prst_i,
  input  logic               psel_i,
  input  logic               penable_i,
  input  logic               pwrite_i,
  input  logic [4:0]         paddr_i,
  input  logic [15:0]        pwdata_i,
  output logic               pready_o,
  output logic               perror_o,
  output logic [15:0]        prdata_o,
  input  logic [NUM_SRC-1:0] irq_i,
  output logic               irq_valid_o,
  output logic [IDW-1:0]     irq_id_o,
  output logic [PRI_W-1:0]   irq_pri_o,
  input  logic               irq_ack_i,
  input  logic               irq_done_i,
  output logic               in_service_o
);

  localparam int unsigned DW   = 16;
  localparam int unsigned IDW1 = IDW + 1;

  localparam logic [4:0] ADDR_MASK = 5'h10;
  localparam logic [4:0] ADDR_PEND = 5'h11;
  localparam logic [4:0] ADDR_MODE = 5'h12;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_ARB   = 4'b0010,
    S_OFFER = 4'b0100,
    S_SERVE = 4'b1000
  } state_t;

  // configuration and status registers
  logic [PRI_W-1:0]   r_pri_cfg [NUM_SRC];
  logic [NUM_SRC-1:0] r_mask;
  logic [NUM_SRC-1:0] r_mode;
  logic [NUM_SRC-1:0] r_pend;
  logic [NUM_SRC-1:0] r_irq_prev;

  // handshake/FSM registers
  state_t             r_state;
  logic               r_irq_valid;
  logic [IDW-1:0]     r_irq_id;
  logic [PRI_W-1:0]   r_irq_pri;
  logic               r_in_service;
  logic [IDW-1:0]     r_rr_ptr;

  logic               w_access;
  logic               w_wr;
  logic               w_rd;
  logic               w_pri_sel;
  logic               w_addr_ok;
  logic [IDW-1:0]     w_pri_idx;
  logic [NUM_SRC-1:0] w_set;
  logic [NUM_SRC-1:0] w_w1c;
  logic [NUM_SRC-1:0] w_ack_clr;
  logic [NUM_SRC-1:0] w_elig;
  logic [IDW-1:0]     w_win_id;
  logic [PRI_W-1:0]   w_win_pri;

  state_t             w_state_nxt;
  logic               w_irq_valid_nxt;
  logic [IDW-1:0]     w_irq_id_nxt;
  logic [PRI_W-1:0]   w_irq_pri_nxt;
  logic               w_in_service_nxt;
  logic [IDW-1:0]     w_rr_ptr_nxt;
  logic               w_ack_take;

  // APB decode: zero-wait, read data valid during setup and access
  assign w_access  = psel_i & penable_i;
  assign w_wr      = w_access & pwrite_i;
  assign w_rd      = psel_i & ~pwrite_i;
  assign w_pri_sel = (32'(paddr_i) < NUM_SRC);
  assign w_pri_idx = paddr_i[IDW-1:0];
  assign w_addr_ok = w_pri_sel | (paddr_i == ADDR_MASK) | (paddr_i == ADDR_PEND) |
                     (paddr_i == ADDR_MODE);

  assign pready_o  = w_access;
  assign perror_o  = w_access & ~w_addr_ok;

  always_comb begin
    prdata_o = '0;
    if (w_rd && !prst_i) begin
      if (w_pri_sel)                  prdata_o = DW'(r_pri_cfg[w_pri_idx]);
      else if (paddr_i == ADDR_MASK)  prdata_o = DW'(r_mask);
      else if (paddr_i == ADDR_PEND)  prdata_o = DW'(r_pend);
      else if (paddr_i == ADDR_MODE)  prdata_o = DW'(r_mode);
    end
  end

  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) r_pri_cfg[i] <= '0;
      r_mask <= '0;
      r_mode <= '0;
    end else if (w_wr) begin
      if (w_pri_sel)                 r_pri_cfg[w_pri_idx] <= pwdata_i[PRI_W-1:0];
      else if (paddr_i == ADDR_MASK) r_mask <= pwdata_i[NUM_SRC-1:0];
      else if (paddr_i == ADDR_MODE) r_mode <= pwdata_i[NUM_SRC-1:0];
    end
  end

  // pending capture: set beats clear when both hit the same bit
  assign w_set = (irq_i & ~r_irq_prev & r_mode) | (irq_i & ~r_mode);
  assign w_w1c = (w_wr && (paddr_i == ADDR_PEND)) ? pwdata_i[NUM_SRC-1:0] : '0;

  always_comb begin
    w_ack_clr = '0;
    w_elig    = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      w_ack_clr[i] = w_ack_take && (r_irq_id == IDW'(i));
      w_elig[i]    = r_pend[i] & r_mask[i] & (r_pri_cfg[i] != '0);
    end
  end

  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      r_pend     <= '0;
      r_irq_prev <= '0;
    end else begin
      r_pend     <= (r_pend & ~(w_w1c | w_ack_clr)) | w_set;
      r_irq_prev <= irq_i;
    end
  end

  // winner: highest priority; first match scanning up from rr_ptr wins ties
  always_comb begin : arb
    logic [IDW1-1:0] v_sum;
    logic [IDW-1:0]  v_idx;
    w_win_id  = '0;
    w_win_pri = '0;
    v_sum     = '0;
    v_idx     = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      v_sum = {1'b0, r_rr_ptr} + IDW1'(k);
      if (v_sum >= IDW1'(NUM_SRC)) v_sum = v_sum - IDW1'(NUM_SRC);
      v_idx = v_sum[IDW-1:0];
      if (w_elig[v_idx] && (r_pri_cfg[v_idx] > w_win_pri)) begin
        w_win_id  = v_idx;
        w_win_pri = r_pri_cfg[v_idx];
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_irq_valid_nxt  = r_irq_valid;
    w_irq_id_nxt     = r_irq_id;
    w_irq_pri_nxt    = r_irq_pri;
    w_in_service_nxt = r_in_service;
    w_rr_ptr_nxt     = r_rr_ptr;
    w_ack_take       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (|w_elig) w_state_nxt = S_ARB;
      end
      S_ARB: begin
        if (|w_elig) begin
          w_irq_id_nxt    = w_win_id;
          w_irq_pri_nxt   = w_win_pri;
          w_irq_valid_nxt = 1'b1;
          w_state_nxt     = S_OFFER;
        end else begin
          w_state_nxt     = S_IDLE;
        end
      end
      S_OFFER: begin
        if (irq_ack_i) begin
          w_ack_take       = 1'b1;
          w_rr_ptr_nxt     = (r_irq_id == IDW'(NUM_SRC - 1)) ? '0 : r_irq_id + IDW'(1);
          w_irq_valid_nxt  = 1'b0;
          w_in_service_nxt = 1'b1;
          w_state_nxt      = S_SERVE;
        end
      end
      S_SERVE: begin
        if (irq_done_i) begin
          w_in_service_nxt = 1'b0;
          w_state_nxt      = S_IDLE;
        end
      end
      default: begin
        w_irq_valid_nxt  = 1'b0;
        w_in_service_nxt = 1'b0;
        w_state_nxt      = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      r_state      <= S_IDLE;
      r_irq_valid  <= 1'b0;
      r_irq_id     <= '0;
      r_irq_pri    <= '0;
      r_in_service <= 1'b0;
      r_rr_ptr     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_irq_valid  <= w_irq_valid_nxt;
      r_irq_id     <= w_irq_id_nxt;
      r_irq_pri    <= w_irq_pri_nxt;
      r_in_service <= w_in_service_nxt;
      r_rr_ptr     <= w_rr_ptr_nxt;
    end
  end

  assign irq_valid_o  = r_irq_valid;
  assign irq_id_o     = r_irq_id;
  assign irq_pri_o    = r_irq_pri;
  assign in_service_o = r_in_service;

endmodule
